// File: rtl/runway_scheduler.sv
// Runway scheduler: queues requests in a small FIFO and grants them to runway A or B; optional RUNWAY_EMERGENCY_EN adds req_emerg head-insert.
// Latency: a request accepted on edge N is granted on edge N+1 when a runway is free; all outputs are registered.
// Backpressure: req_ready = (q_count < QDEPTH) from registered count, no push-through when full; head waits while both runways are occupied.
module runway_scheduler #(
  parameter int OCC_CYCLES = 15,
  parameter int QDEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_dir,
  input  logic [3:0]               req_id,
`ifdef RUNWAY_EMERGENCY_EN
  input  logic                     req_emerg,
`endif
  output logic                     grant_valid,
  output logic                     grant_runway,
  output logic [3:0]               grant_id,
  output logic [3:0]               grant_code,
  output logic                     busy_a,
  output logic                     busy_b,
  output logic [$clog2(QDEPTH):0]  q_count
);

  localparam int                AW       = $clog2(QDEPTH);
  localparam logic [AW:0]       DEPTH_C  = (AW+1)'(QDEPTH);
  localparam logic [7:0]        OCC_LOAD = 8'(OCC_CYCLES - 1);
  localparam logic [3:0]        CODE_A    = 4'b1010;
  localparam logic [3:0]        CODE_B    = 4'b1011;
  localparam logic [3:0]        CODE_HOLD = 4'b1101;
  localparam logic [3:0]        CODE_IDLE = 4'b0000;

  typedef enum logic { RW_FREE = 1'b0, RW_OCC = 1'b1 } rw_state_e;

  // Only the preferred runway is needed downstream, so it is resolved at push time.
  typedef struct packed {
    logic       pref_b;
    logic [3:0] id;
  } entry_t;

  entry_t      mem_q [QDEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_addr;
  logic [AW:0]   count_q, count_d;
  rw_state_e     st_q [2];
  rw_state_e     st_d [2];
  logic [7:0]    cnt_q [2];
  logic [7:0]    cnt_d [2];
  logic          gv_q, gv_d, grw_q, grw_d;
  logic [3:0]    gid_q, gid_d, code_q, code_d;

  logic   push, pop, emerg, in_pref_b, free_a, free_b, sel_b;
  logic [1:0] gnt;
  entry_t head, in_entry;

  assign req_ready = (count_q < DEPTH_C);
  assign push      = req_valid && req_ready;
  assign head      = mem_q[rd_ptr_q];
  assign free_a    = (st_q[0] == RW_FREE);
  assign free_b    = (st_q[1] == RW_FREE);
  assign pop       = (count_q != '0) && (free_a || free_b);
  // Preferred runway when free, otherwise whichever one is free.
  assign sel_b     = head.pref_b ? free_b : !free_a;
  assign gnt       = pop ? (sel_b ? 2'b10 : 2'b01) : 2'b00;
`ifdef RUNWAY_EMERGENCY_EN
  assign emerg     = req_emerg;
`else
  assign emerg     = 1'b0;
`endif

  // Heading class to preferred runway: 00/10 prefer B, 01/11 prefer A.
  always_comb begin
    in_pref_b = 1'b0;
    case (req_dir)
      2'b00, 2'b10: in_pref_b = 1'b1;
      default:      in_pref_b = 1'b0;
    endcase
    in_entry = '{pref_b: in_pref_b, id: req_id};
  end

  // FIFO pointer/count next state; emergency pushes go in just ahead of the (post-pop) head.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    wr_addr  = wr_ptr_q;
    count_d  = count_q;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push) begin
      if (emerg) begin
        rd_ptr_d = rd_ptr_d - 1'b1;
        wr_addr  = rd_ptr_d;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Per-runway occupancy FSM: grant loads OCC_CYCLES-1, count down, free after reaching 0.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      case (st_q[i])
        RW_FREE: if (gnt[i]) begin
          st_d[i]  = RW_OCC;
          cnt_d[i] = OCC_LOAD;
        end
        RW_OCC: begin
          if (cnt_q[i] == 8'd0) st_d[i] = RW_FREE;
          else                  cnt_d[i] = cnt_q[i] - 8'd1;
        end
        default: st_d[i] = RW_FREE;
      endcase
    end
  end

  // Grant outputs and tower code; runway/id hold their last value between grants.
  always_comb begin
    gv_d   = pop;
    grw_d  = grw_q;
    gid_d  = gid_q;
    code_d = CODE_IDLE;
    if (pop) begin
      grw_d  = sel_b;
      gid_d  = head.id;
      code_d = sel_b ? CODE_B : CODE_A;
    end else if ((count_q != '0) && !free_a && !free_b) begin
      code_d = CODE_HOLD;
    end
  end

  // Control state with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= RW_FREE;
        cnt_q[i] <= 8'd0;
      end
      gv_q   <= 1'b0;
      grw_q  <= 1'b0;
      gid_q  <= 4'd0;
      code_q <= CODE_IDLE;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      gv_q   <= gv_d;
      grw_q  <= grw_d;
      gid_q  <= gid_d;
      code_q <= code_d;
    end
  end

  // Storage array carries no reset; entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_addr] <= in_entry;
  end

  assign grant_valid  = gv_q;
  assign grant_runway = grw_q;
  assign grant_id     = gid_q;
  assign grant_code   = code_q;
  assign busy_a       = (st_q[0] == RW_OCC);
  assign busy_b       = (st_q[1] == RW_OCC);
  assign q_count      = count_q;

endmodule

// File: tb/tb_runway_scheduler.sv
module tb_runway_scheduler;
  localparam int OCC = 15;
  localparam int QD  = 4;
`ifdef RUNWAY_EMERGENCY_EN
  localparam bit EMERG_EN = 1'b1;
`else
  localparam bit EMERG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_dir = 2'b00;
  logic [3:0] req_id = 4'd0;
`ifdef RUNWAY_EMERGENCY_EN
  logic       req_emerg = 1'b0;
`endif
  logic       req_ready, grant_valid, grant_runway, busy_a, busy_b;
  logic [3:0] grant_id, grant_code;
  logic [2:0] q_count;

  runway_scheduler #(.OCC_CYCLES(OCC), .QDEPTH(QD)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_dir(req_dir), .req_id(req_id),
`ifdef RUNWAY_EMERGENCY_EN
    .req_emerg(req_emerg),
`endif
    .grant_valid(grant_valid), .grant_runway(grant_runway), .grant_id(grant_id),
    .grant_code(grant_code), .busy_a(busy_a), .busy_b(busy_b), .q_count(q_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of {dir,id}, remaining busy cycles per runway.
  logic [5:0] mq[$];
  int         ba, bb;
  logic       m_gv, m_rw;
  logic [3:0] m_id, m_code;
  logic [3:0] dut_g[$];

  task automatic model_reset();
    mq.delete();
    ba = 0; bb = 0;
    m_gv = 1'b0; m_rw = 1'b0; m_id = 4'd0; m_code = 4'd0;
  endtask

  task automatic model_step(input logic v, input logic [1:0] d, input logic [3:0] id, input logic e);
    bit ready, push, pref_b;
    logic [5:0] hd;
    ready = (mq.size() < QD);
    push  = v && ready;
    m_gv  = 1'b0;
    m_code = 4'b0000;
    if (mq.size() > 0 && (ba == 0 || bb == 0)) begin
      hd     = mq.pop_front();
      pref_b = (hd[5:4] == 2'b00) || (hd[5:4] == 2'b10);
      if (pref_b) m_rw = (bb == 0) ? 1'b1 : 1'b0;
      else        m_rw = (ba == 0) ? 1'b0 : 1'b1;
      m_gv   = 1'b1;
      m_id   = hd[3:0];
      m_code = m_rw ? 4'b1011 : 4'b1010;
    end else if (mq.size() > 0 && ba > 0 && bb > 0) begin
      m_code = 4'b1101;
    end
    if (ba > 0) ba--;
    if (bb > 0) bb--;
    if (m_gv) begin
      if (m_rw) bb = OCC;
      else      ba = OCC;
    end
    if (push) begin
      if (e) mq.push_front({d, id});
      else   mq.push_back({d, id});
    end
  endtask

  task automatic compare_all();
    check_val("grant_valid", grant_valid, m_gv);
    check_val("grant_code", grant_code, m_code);
    check_val("busy_a", busy_a, 32'(ba > 0));
    check_val("busy_b", busy_b, 32'(bb > 0));
    check_val("q_count", q_count, mq.size());
    check_val("req_ready", req_ready, 32'(mq.size() < QD));
    if (m_gv) begin
      check_val("grant_runway", grant_runway, m_rw);
      check_val("grant_id", grant_id, m_id);
    end
    if (grant_valid) dut_g.push_back(grant_id);
  endtask

  // One cycle: drive inputs after a falling edge, advance model, check at next falling edge.
  task automatic step(input logic v, input logic [1:0] d, input logic [3:0] id, input logic e);
    logic ee;
    ee = EMERG_EN ? e : 1'b0;
    req_valid = v; req_dir = d; req_id = id;
`ifdef RUNWAY_EMERGENCY_EN
    req_emerg = ee;
`endif
    model_step(v, d, id, ee);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 4'd0, 1'b0);
  endtask

  task automatic wait_both_free();
    for (int k = 0; k < 40 && (busy_a || busy_b); k++) idle();
    check_val("both_free", {busy_a, busy_b}, 2'b00);
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge.
  task automatic do_reset();
    req_valid = 1'b0;
`ifdef RUNWAY_EMERGENCY_EN
    req_emerg = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_grant_valid", grant_valid, 1'b0);
    check_val("rst_grant_code", grant_code, 4'b0000);
    check_val("rst_grant_id", grant_id, 4'd0);
    check_val("rst_grant_runway", grant_runway, 1'b0);
    check_val("rst_q_count", q_count, 3'd0);
    check_val("rst_req_ready", req_ready, 1'b1);
    check_val("rst_busy", {busy_a, busy_b}, 2'b00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();
  endtask

  initial begin
    int blen;
    model_reset();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Single request: dir 01 -> runway A one cycle after accept, busy for OCC cycles.
    step(1'b1, 2'b01, 4'd3, 1'b0);
    idle();
    check_val("single_gv", grant_valid, 1'b1);
    check_val("single_code", grant_code, 4'b1010);
    blen = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy_a) blen++;
      idle();
    end
    check_val("busy_a_len", blen, OCC);

    // Preference and fallback.
    step(1'b1, 2'b00, 4'd1, 1'b0);
    step(1'b1, 2'b10, 4'd2, 1'b0);
    check_val("pref_id1", {grant_valid, grant_runway, grant_id}, {1'b1, 1'b1, 4'd1});
    idle();
    check_val("fallback_id2", {grant_valid, grant_runway, grant_code}, {1'b1, 1'b0, 4'b1010});

    // Hold while both busy.
    step(1'b1, 2'b01, 4'd5, 1'b0);
    for (int k = 0; k < 40 && !grant_valid; k++) idle();
    check_val("hold_grant_id", {grant_valid, grant_id}, {1'b1, 4'd5});

    // Full FIFO.
    wait_both_free();
    step(1'b1, 2'b00, 4'd1, 1'b0);
    step(1'b1, 2'b00, 4'd2, 1'b0);
    for (int k = 3; k <= 6; k++) step(1'b1, 2'(k), 4'(k), 1'b0);
    check_val("full_ready", req_ready, 1'b0);
    check_val("full_count", q_count, 3'd4);
    step(1'b1, 2'b11, 4'd7, 1'b0);
    check_val("full_ignored", q_count, 3'd4);
    for (int k = 0; k < 40; k++) step(1'b1, 2'($urandom), 4'($urandom), 1'b0);

    // Reset mid-operation with three queued.
    for (int k = 0; k < 60 && q_count != 3'd3; k++) idle();
    check_val("pre_reset_count", q_count, 3'd3);
    do_reset();
    for (int k = 0; k < 20; k++) idle();

`ifdef RUNWAY_EMERGENCY_EN
    wait_both_free();
    dut_g.delete();
    step(1'b1, 2'b00, 4'd10, 1'b0);
    step(1'b1, 2'b00, 4'd11, 1'b0);
    step(1'b1, 2'b00, 4'd1, 1'b0);
    step(1'b1, 2'b00, 4'd2, 1'b0);
    step(1'b1, 2'b00, 4'd9, 1'b1);
    for (int k = 0; k < 60; k++) idle();
    check_val("emerg_count", dut_g.size(), 5);
    if (dut_g.size() >= 4) begin
      check_val("emerg_first", dut_g[2], 4'd9);
      check_val("emerg_then", dut_g[3], 4'd1);
    end
`endif

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      else step(1'($urandom_range(0, 9) < 6), 2'($urandom), 4'($urandom),
                1'($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 2000000", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/runway_scheduler.md
# runway_scheduler

Queues runway requests from the approach/departure front end and assigns them to the two runways, A and B, one grant per cycle. Each runway is held for a fixed occupancy time after a grant. The block sits above the runway signal logic: its `grant_code` drives the same 4-bit tower signal encoding (A=1010, B=1011, hold=1101). It replaces ad-hoc edge-triggered assignment with a buffered, clocked scheduler.

## Interface
- `OCC_CYCLES`, default 15: cycles a runway stays occupied after a grant; legal range 2..255.
- `QDEPTH`, default 4: request FIFO depth; must be a power of two, 2..16.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: a request is offered this cycle.
- `req_ready` output 1: the FIFO can accept a request; equals (count < QDEPTH).
- `req_dir` input 2: heading class of the request; sets the preferred runway.
- `req_id` input 4: aircraft tag, returned with the grant.
- `grant_valid` output 1: one-cycle pulse when a request is dispatched.
- `grant_runway` output 1: 0 = A, 1 = B; meaningful only when `grant_valid`=1.
- `grant_id` output 4: tag of the dispatched request.
- `grant_code` output 4: 1010 = A granted, 1011 = B granted, 1101 = head waiting with both runways busy, 0000 = idle.
- `busy_a`, `busy_b` output 1 each: runway occupied.
- `q_count` output $clog2(QDEPTH)+1: number of queued requests.

## Operation
- FIFO:
  - A push happens when `req_valid` && `req_ready`.
  - `req_ready` is derived from the registered count. There is no push-through when the FIFO is full.
  - Pointers wrap modulo QDEPTH.
- Per-runway FSM, FREE → OCC on grant:
  - On grant, the counter loads OCC_CYCLES-1.
  - In OCC the counter decrements each cycle.
  - When it reaches 0 in OCC, the next edge returns the runway to FREE.
  - `busy_x` = (state == OCC).
- Dispatch, evaluated each cycle from registered state:
  - Dispatch occurs only if the FIFO is non-empty and at least one runway is FREE.
  - Preferred runway: `req_dir` 00 or 10 → B; 01 or 11 → A.
  - If the preferred runway is busy, use the other one. If both are free, use the preferred one.
  - The head is popped, and `grant_valid`, `grant_runway` and `grant_id` are registered on the same edge.
- `grant_code` is registered:
  - 1010 or 1011 on the grant cycle.
  - 1101 while the FIFO is non-empty and both runways are busy.
  - Otherwise 0000.
- A push and a pop in the same cycle are both performed; count is unchanged.
- A runway freeing in the same cycle another request is waiting: that runway is FREE at this edge, so the grant lands on the next edge. No cycle is wasted beyond this.
- Reset, asserted at any time, clears everything immediately:
  - FIFO emptied, count 0, both runways FREE, counters 0.
  - `grant_valid`=0, `grant_runway`=0, `grant_id`=0, `grant_code`=0000.
  - `req_ready`=1.
  - In-flight occupancy is discarded.

## Timing
- Latency from request acceptance (edge N, empty FIFO, a runway free) to `grant_valid` = 1 on edge N+1, i.e. one cycle after the accept.
- Throughput is at most one grant per cycle; two grants back-to-back are only possible when both runways are free.
- `busy_x` is high for exactly OCC_CYCLES cycles, starting at the grant edge.
- A runway is re-grantable on the edge after its `busy_x` falls.
- `grant_valid` is never high for two cycles on the same runway within OCC_CYCLES.

## Configuration
- `RUNWAY_EMERGENCY_EN`
  - Defined:
    - Adds input `req_emerg` (1 bit).
    - An accepted request with `req_emerg`=1 is inserted at the FIFO head (read pointer decremented), ahead of all queued entries.
    - Full-FIFO rules are unchanged: `req_ready` still gates the push.
    - If an emergency push and a dispatch pop coincide, the pop takes the old head and the emergency entry becomes the new head.
  - Undefined: the port is absent and all requests are FIFO-ordered.

## Test plan
- **Reset and single request.** Reset, then push dir=01, id=3. Expected: grant on the next edge with runway A, code 1010. `busy_a` stays high exactly 15 cycles, then falls.
- **Preference and fallback.** Push dir=00 (id 1), then dir=10 (id 2) on consecutive cycles. Expected: id 1 → B, id 2 → A, codes 1011 then 1010.
- **Hold.** With both runways busy, push id 5. Expected: `grant_code`=1101 until the first runway frees; id 5 is granted on the edge after that runway's `busy` falls.
- **Full FIFO.** With both runways busy, push 4 requests. Expected: `req_ready`=0 and `q_count`=4; a 5th `req_valid` is ignored. A simultaneous push and pop keeps `q_count` constant.
- **Reset mid-operation.** Assert `rst_n` low while busy with 3 requests queued. Expected: all outputs return to reset values asynchronously; no grant after release until a new push.
- **Emergency (with `RUNWAY_EMERGENCY_EN` defined).** Queue ids 1 and 2, then push id 9 with `req_emerg`=1. Expected: id 9 is granted before ids 1 and 2.
